bus_op_sequencer: RTL
=====================

BUS_OP_SEQUENCER -- requirements
Module: bus_op_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, request address width.
REQ-002 Parameter LINE_W, default 512, cache line / shared bus width.
REQ-003 Parameter SNOOP_WAIT, default 2, cycles between address phase end and snoop sample; legal range 1-15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  L2 controller presents a bus request.
REQ-007 req_ready  output  1  sequencer accepts the request this cycle.
REQ-008 req_op  input  8  ASCII op code: 'R' read, 'M' read-with-intent-to-modify, 'I' invalidate, 'W' write-back.
REQ-009 req_addr  input  ADDR_W  line address.
REQ-010 req_data  input  LINE_W  write-back data; used for 'W' only.
REQ-011 shared_bus  output  LINE_W  address (zero-extended) in address phase, data in data phase, zero otherwise.
REQ-012 shared_op  output  8  ASCII op driven during address phase, 8'h00 otherwise.
REQ-013 snoop  input  2  snoop result: 00 NOHIT, 01 HIT, 10 HITM, 11 reserved.
REQ-014 rsp_valid  output  1  one-cycle completion pulse.
REQ-015 rsp_state  output  2  resulting MESI state: I=00, S=01, E=10, M=11.
REQ-016 rsp_retry  output  1  transaction aborted; requester re-issues.
REQ-017 rsp_err  output  1  unrecognised op code.
REQ-018 txn_count  output  16  count of address phases issued.

Function
REQ-019 States SHALL be IDLE, ADDR, SNOOP, DATA, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; req_op/req_addr/req_data captured into internal registers on handshake.
REQ-021 IDLE -> ADDR on handshake with legal op; IDLE -> RESP with rsp_err=1, rsp_state=I, no bus activity, txn_count unchanged on illegal op.
REQ-022 ADDR lasts exactly 1 cycle: shared_op = captured op, shared_bus = captured address; txn_count increments by 1, wrapping 16'hFFFF -> 0.
REQ-023 SNOOP SHALL last exactly SNOOP_WAIT cycles via down-counter; snoop sampled on the last SNOOP cycle only.
REQ-024 'W': SNOOP -> DATA (shared_bus = captured data, 1 cycle) -> RESP, rsp_state=I, snoop ignored.
REQ-025 'R': NOHIT -> E, HIT -> S, HITM -> rsp_retry=1, rsp_state=I.
REQ-026 'M': NOHIT or HIT -> M; HITM -> rsp_retry=1, rsp_state=I.
REQ-027 'I': any non-reserved result -> M (upgrade); HITM on 'I' -> rsp_state=M, no retry.
REQ-028 Reserved snoop 11 on 'R', 'M' or 'I' SHALL be treated as HITM.
REQ-029 RESP lasts 1 cycle: rsp_valid=1 with rsp_state/rsp_retry/rsp_err, then IDLE; outside RESP rsp_* = 0.
REQ-030 Request-to-rsp_valid latency SHALL be SNOOP_WAIT+2 cycles ('R','M','I'), SNOOP_WAIT+3 ('W'), 1 (illegal op).
REQ-031 Inputs req_* changing after handshake SHALL NOT affect the transaction in flight.
REQ-032 A new request presented during RESP SHALL NOT be accepted until the following IDLE cycle (no back-to-back acceptance).

Reset
REQ-033 rst_n low SHALL immediately force IDLE, req_ready=1, shared_bus=0, shared_op=8'h00, rsp_valid=0, rsp_state=00, rsp_retry=0, rsp_err=0, txn_count=0, snoop counter=0.
REQ-034 Reset asserted mid-transaction SHALL abandon it with no rsp_valid pulse; first post-reset request behaves as from power-up.

Verification
REQ-035 'R' at 32'h0000_1040, SNOOP_WAIT=2, snoop=00 -> shared_op='R' for 1 cycle with shared_bus=...1040; rsp_valid 4 cycles after handshake, rsp_state=10, txn_count=1.
REQ-036 'M' with snoop=10 -> rsp_valid, rsp_retry=1, rsp_state=00; re-issued 'M' with snoop=01 -> rsp_state=11, txn_count=2.
REQ-037 'W' with req_data=512'hA5...A5 -> address phase, SNOOP_WAIT cycles, one data cycle with shared_bus=A5...A5, rsp_state=00 after 5 cycles.
REQ-038 req_op='Z' -> rsp_valid next cycle with rsp_err=1, shared_op stays 00, txn_count unchanged.
REQ-039 rst_n pulsed low during SNOOP -> outputs at reset values asynchronously, no rsp_valid; subsequent 'I' completes with rsp_state=11.
REQ-040 Preload 65535 transactions, issue one more -> txn_count wraps to 0.

Source files
------------

// File: rtl/bus_op_sequencer.sv
// bus_op_sequencer: sequences L2 bus ops through address, snoop, data and response phases
module bus_op_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 512,
  parameter int SNOOP_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_data,
  output logic [LINE_W-1:0] shared_bus,
  output logic [7:0]        shared_op,
  input  logic [1:0]        snoop,
  output logic              rsp_valid,
  output logic [1:0]        rsp_state,
  output logic              rsp_retry,
  output logic              rsp_err,
  output logic [15:0]       txn_count
);
  typedef enum logic [2:0] {IDLE, ADDR, SNOOP, DATA, RESP} state_t;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_M = 8'h4D;
  localparam logic [7:0] OP_I = 8'h49;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;
  state_t              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         txn_q, txn_d;
  logic [1:0]          st_q, st_d;
  logic                retry_q, retry_d;
  logic                err_q, err_d;
  logic                legal;
  logic                hitm;
  assign legal = (req_op == OP_R) || (req_op == OP_M) || (req_op == OP_I) || (req_op == OP_W);
  // Reserved snoop code 11 is folded into HITM together with 10.
  assign hitm  = snoop[1];
  // State and captured-request registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      txn_q   <= '0;
      st_q    <= ST_I;
      retry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
      st_q    <= st_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end
  // Next-state logic: capture on handshake, time the snoop window, resolve the MESI result.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    st_d    = st_q;
    retry_d = retry_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        st_d    = ST_I;
        retry_d = 1'b0;
        err_d   = 1'b0;
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          data_d  = req_data;
          err_d   = !legal;
          state_d = legal ? ADDR : RESP;
        end
      end
      ADDR: begin
        cnt_d   = 4'(SNOOP_WAIT - 1);
        txn_d   = txn_q + 16'd1;
        state_d = SNOOP;
      end
      SNOOP: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          retry_d = ((op_q == OP_R) || (op_q == OP_M)) && hitm;
          st_d    = (op_q == OP_W) ? ST_I :
                    (op_q == OP_I) ? ST_M :
                    hitm           ? ST_I :
                    (op_q == OP_M) ? ST_M :
                    snoop[0]       ? ST_S : ST_E;
          state_d = (op_q == OP_W) ? DATA : RESP;
        end
      end
      DATA:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign req_ready  = state_q == IDLE;
  assign shared_op  = (state_q == ADDR) ? op_q : 8'h00;
  assign shared_bus = (state_q == ADDR) ? LINE_W'(addr_q) : (state_q == DATA) ? data_q : '0;
  assign rsp_valid  = state_q == RESP;
  assign rsp_state  = rsp_valid ? st_q : ST_I;
  assign rsp_retry  = rsp_valid & retry_q;
  assign rsp_err    = rsp_valid & err_q;
  assign txn_count  = txn_q;
endmodule
